// File: rtl/ln_pkg.sv
// Shared types and constants for the layer-norm sharing scheduler.
package ln_pkg;
  typedef logic signed [7:0] data_t;

  localparam int unsigned LN_VEC_LEN = 8;
  localparam int unsigned LN_MAX_REQ = 8;

  typedef logic [$clog2(LN_MAX_REQ)-1:0] req_id_t;

  typedef enum logic {
    IDLE,
    BURST
  } sched_state_t;
endpackage

// File: rtl/ln_share_sched_if.sv
// Requester and engine-side signal bundle for ln_share_sched.
interface ln_share_sched_if
  import ln_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req_valid;
  data_t              req_data [NUM_REQ];
  logic [NUM_REQ-1:0] req_ready;
  logic               ln_in_valid;
  data_t              ln_in_data;
  logic               ln_out_valid;
  data_t              ln_out_data;
  logic [NUM_REQ-1:0] rsp_valid;
  data_t              rsp_data;
  logic               err;

  modport master (
    input  req_valid, req_data, ln_out_valid, ln_out_data,
    output req_ready, ln_in_valid, ln_in_data, rsp_valid, rsp_data, err
  );

  modport slave (
    output req_valid, req_data, ln_out_valid, ln_out_data,
    input  req_ready, ln_in_valid, ln_in_data, rsp_valid, rsp_data, err
  );
endinterface

// File: rtl/ln_tag_fifo.sv
// Owner-tag FIFO: records which requester owns each in-flight vector.
module ln_tag_fifo
  import ln_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  req_id_t push_id,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output req_id_t head
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  req_id_t     mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  // Status from registered pointers only, so a same-cycle pop never frees room for a push
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_push = push && !full;
    do_pop  = pop && !empty;
    head    = mem[rd_ptr[AW-1:0]];
  end

  // Pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Tag storage
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_id;
  end
endmodule

// File: rtl/ln_share_sched.sv
// Round-robin vector scheduler sharing one LN engine among NUM_REQ requesters.
module ln_share_sched
  import ln_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned VEC_LEN   = LN_VEC_LEN,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  ln_share_sched_if.master bus
);
  localparam int unsigned CW = $clog2(VEC_LEN);

  sched_state_t       state;
  req_id_t            owner;
  req_id_t            rr_ptr;
  req_id_t            win;
  req_id_t            sel;
  req_id_t            head;
  logic [CW-1:0]      in_cnt;
  logic [CW-1:0]      out_cnt;
  logic [NUM_REQ-1:0] sel_mask;
  logic [NUM_REQ-1:0] head_mask;
  logic [NUM_REQ-1:0] ready;
  logic               found;
  logic               accept;
  logic               push;
  logic               pop;
  logic               out_ok;
  logic               fifo_full;
  logic               fifo_empty;
  data_t              acc_data;

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!found && bus.req_valid[j] && (j == (32'(rr_ptr) + i) % NUM_REQ)) begin
          found = 1'b1;
          win   = req_id_t'(j);
        end
      end
    end
  end

  // Grant mask, accept detection and selected sample
  always_comb begin
    sel       = (state == IDLE) ? win : owner;
    sel_mask  = '0;
    head_mask = '0;
    acc_data  = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (req_id_t'(j) == sel) begin
        sel_mask[j] = 1'b1;
        acc_data    = bus.req_data[j];
      end
      if (req_id_t'(j) == head) head_mask[j] = 1'b1;
    end
    if (state == IDLE) ready = (found && !fifo_full) ? sel_mask : '0;
    else               ready = sel_mask;
    accept = |(ready & bus.req_valid);
    push   = (state == IDLE) && accept;
    out_ok = bus.ln_out_valid && !fifo_empty;
    pop    = out_ok && (out_cnt == CW'(VEC_LEN - 1));
  end

  assign bus.req_ready = ready;

  // Grant FSM with registered forward path to the engine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      owner           <= '0;
      rr_ptr          <= '0;
      in_cnt          <= '0;
      bus.ln_in_valid <= 1'b0;
      bus.ln_in_data  <= '0;
    end else begin
      bus.ln_in_valid <= accept;
      if (accept) bus.ln_in_data <= acc_data;
      case (state)
        IDLE: begin
          if (accept) begin
            owner  <= win;
            in_cnt <= CW'(1);
            state  <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            if (in_cnt == CW'(VEC_LEN - 1)) begin
              in_cnt <= '0;
              rr_ptr <= (owner == req_id_t'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
              state  <= IDLE;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response routing by FIFO head tag; orphan engine output sets sticky err
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt       <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
      bus.err       <= 1'b0;
    end else begin
      bus.rsp_valid <= out_ok ? head_mask : '0;
      if (out_ok) begin
        bus.rsp_data <= bus.ln_out_data;
        out_cnt      <= pop ? '0 : out_cnt + 1'b1;
      end
      if (bus.ln_out_valid && fifo_empty) bus.err <= 1'b1;
    end
  end

  ln_tag_fifo #(
    .DEPTH(TAG_DEPTH)
  ) u_tag_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .push_id(win),
    .pop    (pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (head)
  );
endmodule

// File: tb/tb_ln_share_sched.sv
// Directed scoreboard bench for ln_share_sched with a simple in-bench engine model.
module tb_ln_share_sched;
  import ln_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  ln_share_sched_if #(.NUM_REQ(4)) bus ();

  ln_share_sched #(
    .NUM_REQ  (4),
    .VEC_LEN  (8),
    .TAG_DEPTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err = 0;
  data_t       rd [4];
  data_t       in_q[$];
  data_t       eng_q[$];
  int unsigned own_q[$];
  bit          pend_in;
  bit          eng_en;
  int          eng_cnt;
  logic [3:0]  exp_rsp_mask;
  data_t       exp_rsp_d;
  bit          exp_err;
  bit          inject;
  data_t       inject_d;

  function automatic data_t eng_f(input data_t x);
    return ~x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare registered outputs, then drive the engine model for this cycle
  task automatic tick();
    data_t x;
    bit    have_x;
    have_x = 1'b0;
    @(posedge clk);
    #1;
    check("ln_in_valid", bus.ln_in_valid, pend_in);
    if (pend_in) begin
      x = in_q.pop_front();
      have_x = 1'b1;
      check("ln_in_data", bus.ln_in_data, x);
    end
    pend_in = 1'b0;
    check("rsp_valid", bus.rsp_valid, exp_rsp_mask);
    if (exp_rsp_mask != 4'b0) check("rsp_data", bus.rsp_data, exp_rsp_d);
    check("err", bus.err, exp_err);
    exp_rsp_mask = 4'b0;
    bus.ln_out_valid = 1'b0;
    bus.ln_out_data  = '0;
    if (inject) begin
      bus.ln_out_valid = 1'b1;
      bus.ln_out_data  = inject_d;
      inject = 1'b0;
    end else if (eng_en && eng_q.size() > 0 && own_q.size() > 0) begin
      exp_rsp_d        = eng_f(eng_q.pop_front());
      bus.ln_out_valid = 1'b1;
      bus.ln_out_data  = exp_rsp_d;
      exp_rsp_mask     = 4'(1 << own_q[0]);
      eng_cnt++;
      if (eng_cnt == 8) begin
        eng_cnt = 0;
        void'(own_q.pop_front());
      end
    end
    if (have_x) eng_q.push_back(x);
  endtask

  task automatic drive(input logic [3:0] vld, input logic [3:0] exp_rdy);
    tick();
    bus.req_valid = vld;
    for (int j = 0; j < 4; j++) bus.req_data[j] = rd[j];
    #1;
    check("req_ready", bus.req_ready, exp_rdy);
    for (int j = 0; j < 4; j++) begin
      if (vld[j] && exp_rdy[j]) begin
        pend_in = 1'b1;
        in_q.push_back(rd[j]);
      end
    end
  endtask

  task automatic do_reset();
    bus.req_valid    = '0;
    bus.ln_out_valid = 1'b0;
    bus.ln_out_data  = '0;
    for (int j = 0; j < 4; j++) bus.req_data[j] = '0;
    rst_n = 1'b0;
    #1;
    check("rst_req_ready", bus.req_ready, 4'b0);
    check("rst_ln_in_valid", bus.ln_in_valid, 1'b0);
    check("rst_ln_in_data", bus.ln_in_data, 8'h00);
    check("rst_rsp_valid", bus.rsp_valid, 4'b0);
    check("rst_rsp_data", bus.rsp_data, 8'h00);
    check("rst_err", bus.err, 1'b0);
    in_q.delete();
    eng_q.delete();
    own_q.delete();
    pend_in      = 1'b0;
    eng_cnt      = 0;
    exp_rsp_mask = 4'b0;
    exp_err      = 1'b0;
    inject       = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(4'b0000, 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int j = 0; j < 4; j++) rd[j] = '0;
    eng_en   = 1'b1;
    inject_d = 8'sd5;
    #2;
    do_reset();

    // Single requester 0 sends 8..64
    own_q.push_back(0);
    for (int k = 0; k < 8; k++) begin
      rd[0] = data_t'(8 * (k + 1));
      drive(4'b0001, 4'b0001);
    end
    idle(14);

    // Requesters 0 and 2 continuously from reset: vector-wise alternation, no gaps
    do_reset();
    for (int k = 0; k < 32; k++) begin
      if (k % 8 == 0) own_q.push_back(((k / 8) % 2 == 0) ? 0 : 2);
      rd[0] = data_t'(k);
      rd[2] = data_t'(64 + k);
      drive(4'b0101, ((k / 8) % 2 == 0) ? 4'b0001 : 4'b0100);
    end
    idle(14);

    // Requester 1 with a 3-cycle hole after sample 4; others held off until sample 8
    own_q.push_back(1);
    for (int k = 0; k < 11; k++) begin
      rd[0] = data_t'(-10 - k);
      rd[1] = data_t'(20 + k);
      rd[3] = data_t'(40 + k);
      if (k == 0)     drive(4'b0010, 4'b0010);
      else if (k < 4) drive(4'b1011, 4'b0010);
      else if (k < 7) drive(4'b1001, 4'b0010);
      else            drive(4'b1011, 4'b0010);
    end
    own_q.push_back(3);
    for (int k = 0; k < 8; k++) begin
      rd[0] = data_t'(-30 - k);
      rd[3] = data_t'(50 + k);
      drive(4'b1001, 4'b1000);
    end
    idle(14);

    // Engine stalled: 4 vectors fill the tag FIFO, grant blocked until the cycle after the pop
    eng_en = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k % 8 == 0) own_q.push_back(0);
      rd[0] = data_t'(k - 16);
      drive(4'b0001, 4'b0001);
    end
    for (int k = 0; k < 3; k++) drive(4'b0001, 4'b0000);
    eng_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == 8) own_q.push_back(0);
      rd[0] = data_t'(100 + k);
      drive(4'b0001, (k < 8) ? 4'b0000 : 4'b0001);
    end
    idle(45);

    // Engine output with no vector in flight: dropped, sticky err
    inject = 1'b1;
    drive(4'b0000, 4'b0000);
    exp_err = 1'b1;
    idle(6);

    // Reset after sample 5 of a vector; restart arbitrates from requester 0
    eng_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rd[2] = data_t'(70 + k);
      drive(4'b0100, 4'b0100);
    end
    tick();
    do_reset();
    eng_en = 1'b1;
    own_q.push_back(0);
    for (int k = 0; k < 8; k++) begin
      rd[0] = data_t'(-1 - k);
      rd[2] = data_t'(90 + k);
      drive(4'b0101, 4'b0001);
    end
    idle(14);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/ln_share_sched.md
# ln_share_sched

Round-robin scheduler that shares one layer-norm engine (8-sample vector in, 8 normalized samples out) among several streaming requesters. It grants one requester per whole vector, forwards that vector's samples to the engine, and records the owner in a tag FIFO. Engine output samples go back to the correct requester. It sits between the requester front-ends and the single LN engine instance.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- VEC_LEN, 8: samples per vector; must match the engine.
- TAG_DEPTH, 4: in-flight vector capacity of the tag FIFO (power of 2).
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester sample valid.
- req_data  in  NUM_REQ x 8 signed  per-requester sample.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- ln_in_valid  out  1  sample valid to engine.
- ln_in_data  out  8 signed  sample to engine.
- ln_out_valid  in  1  engine output valid.
- ln_out_data  in  8 signed  engine output sample.
- rsp_valid  out  NUM_REQ  one-hot response valid.
- rsp_data  out  8 signed  response sample, shared by all requesters.
- err  out  1  sticky: engine output arrived with tag FIFO empty.

## Operation
- Transfer on req_valid[i] && req_ready[i].
- FSM has two states, IDLE and BURST.
- IDLE:
  - If any req_valid is high and the FIFO is not full, the winner is the first requester with valid high at or after rr_ptr (wrapping).
  - req_ready[winner] is driven combinationally in the same cycle, so the first sample is accepted that cycle.
  - On that acceptance: push the winner id into the FIFO, set owner, set in_cnt=1, go to BURST.
- BURST:
  - req_ready[owner]=1; all other ready bits are 0.
  - Each accept increments in_cnt.
  - The accept with in_cnt==VEC_LEN-1 ends the vector: set rr_ptr=(owner+1) mod NUM_REQ, return to IDLE.
- Gaps are allowed. If the owner drops valid mid-vector, the grant is held and ln_in_valid stays low for those cycles. The engine tolerates input gaps.
- Output side:
  - out_cnt counts ln_out_valid cycles.
  - Each sample is routed to the id at the FIFO head.
  - On the VEC_LEN-th sample, pop the FIFO and clear out_cnt.
- If ln_out_valid arrives with the FIFO empty: drop the sample, set err (cleared only by reset).
- FIFO full: a push is allowed only if the FIFO is not full at the start of the cycle. A same-cycle pop does not enable a push (no bypass).
- Simultaneous push and pop on a non-full FIFO: both happen; occupancy is unchanged.
- Arithmetic: in_cnt and out_cnt are $clog2(VEC_LEN) bits and wrap to 0. FIFO pointers carry one extra bit for full/empty detection.

## Timing
- Reset values: req_ready=0, ln_in_valid=0, ln_in_data=0, rsp_valid=0, rsp_data=0, err=0, rr_ptr=0, FIFO empty, state IDLE, counters 0.
- Reset asserted mid-vector aborts it; no partial-vector state survives.
- ln_in_valid/ln_in_data are registered: 1 cycle after the accept.
- rsp_valid/rsp_data are registered: 1 cycle after ln_out_valid.
- Back-to-back vectors from different requesters are possible with zero idle cycles: the IDLE accept coincides with the cycle after the last BURST accept.
- Total requester-to-response latency = engine latency + 2 cycles.

## Structure
- Shared package ln_pkg:
  - typedef data_t (logic signed [7:0]).
  - constant LN_VEC_LEN=8.
  - typedef req_id_t sized for 8 requesters.
- One sub-module, ln_tag_fifo: synchronous FIFO of req_id_t with DEPTH parameter, push/pop/full/empty/head ports.
- Round-robin pick and FSM stay in the top.

## Test plan
- Single requester 0 sends 8,16,24,...,64 → ln_in_data carries the same 8 values 1 cycle later. The engine model's 8 outputs appear on rsp_valid=4'b0001 one cycle after each ln_out_valid.
- Requesters 0 and 2 both valid continuously from reset → grants alternate 0,2,0,2 vector-wise. No gap between vectors on ln_in_valid.
- Requester 1 drops valid for 3 cycles after sample 4 → req_ready[1] stays high throughout, ln_in_valid shows a 3-cycle hole, and no other requester is granted until sample 8.
- Engine model stalls outputs; 4 vectors are accepted → FIFO full, all req_ready=0. The first 8 outputs pop one entry, and req_ready returns on the following cycle, not the same cycle.
- Inject ln_out_valid with the FIFO empty → no rsp_valid bit set, err=1 and stays 1 until rst_n.
- Assert rst_n low after sample 5 of a vector → all outputs 0 immediately. After release, the next vector is granted starting at requester 0.
